// File: rtl/video_stream_pkg.sv
// rtl/video_stream_pkg.sv - shared timing constants, pattern codes and pixel helper for the test source
package video_stream_pkg;

  localparam int CNT_W = 12;
  localparam int CNT_MAX_TOTAL = 1 << CNT_W;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_FLAT  = 2'd3;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic [7:0] pattern_pixel(input logic [1:0] pat, input cnt_t h, input cnt_t v);
    logic [7:0] pix;
    case (pat)
      PAT_HRAMP: pix = h[7:0];
      PAT_VRAMP: pix = v[7:0];
      PAT_CHECK: pix = (h[5] ^ v[5]) ? 8'hFF : 8'h00;
      default:   pix = 8'h80;
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/video_test_source_if.sv
// rtl/video_test_source_if.sv - pixel stream bundle (luma, valid, syncs, frame status)
interface video_test_source_if;

  logic [7:0] y_o;
  logic       dv_o;
  logic       hs_o;
  logic       vs_o;
  logic       sof_o;
  logic       busy_o;

  modport master (output y_o, dv_o, hs_o, vs_o, sof_o, busy_o);
  modport slave  (input  y_o, dv_o, hs_o, vs_o, sof_o, busy_o);

endinterface

// File: rtl/video_timing_counter.sv
// rtl/video_timing_counter.sv - h/v raster counters with wrap flags and combinational sync/dv decode
module video_timing_counter
  import video_stream_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720P,
  parameter int H_FP     = H_FP_720P,
  parameter int H_SYNC   = H_SYNC_720P,
  parameter int H_BP     = H_BP_720P,
  parameter int V_ACTIVE = V_ACTIVE_720P,
  parameter int V_FP     = V_FP_720P,
  parameter int V_SYNC   = V_SYNC_720P,
  parameter int V_BP     = V_BP_720P
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output cnt_t h_cnt_o,
  output cnt_t v_cnt_o,
  output logic frame_start_o,
  output logic frame_end_o,
  output logic dv_o,
  output logic hs_o,
  output logic vs_o
);

  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam int   HS_START = H_ACTIVE + H_FP;
  localparam int   HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int   VS_START = V_ACTIVE + V_FP;
  localparam int   VS_END   = V_ACTIVE + V_FP + V_SYNC;

  if (H_TOTAL > CNT_MAX_TOTAL) begin : g_h_total_chk
    $error("H_TOTAL does not fit the horizontal counter");
  end
  if (V_TOTAL > CNT_MAX_TOTAL) begin : g_v_total_chk
    $error("V_TOTAL does not fit the vertical counter");
  end

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;
  logic line_end;

  assign line_end      = (h_cnt_q == H_LAST);
  assign frame_end_o   = run_i && line_end && (v_cnt_q == V_LAST);
  assign frame_start_o = run_i && (h_cnt_q == '0) && (v_cnt_q == '0);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!run_i) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (line_end) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
    end else begin
      h_cnt_d = h_cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // hs runs on every line, blanking lines included; vs covers whole lines
  assign dv_o = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
  assign hs_o = (int'(h_cnt_q) >= HS_START) && (int'(h_cnt_q) < HS_END);
  assign vs_o = (int'(v_cnt_q) >= VS_START) && (int'(v_cnt_q) < VS_END);

  assign h_cnt_o = h_cnt_q;
  assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/video_test_source.sv
// rtl/video_test_source.sv - raster test-pattern source: run control, pattern mux, registered outputs
module video_test_source
  import video_stream_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720P,
  parameter int H_FP     = H_FP_720P,
  parameter int H_SYNC   = H_SYNC_720P,
  parameter int H_BP     = H_BP_720P,
  parameter int V_ACTIVE = V_ACTIVE_720P,
  parameter int V_FP     = V_FP_720P,
  parameter int V_SYNC   = V_SYNC_720P,
  parameter int V_BP     = V_BP_720P,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic [1:0]          pattern_i,
  video_test_source_if.master vid
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0] state_q, state_d;
  logic [1:0] pat_q, pat_d;
  logic [7:0] y_q, y_d;
  logic       dv_q, hs_q, vs_q, sof_q;
  logic       run;
  cnt_t       h_cnt, v_cnt;
  logic       frame_start, frame_end, t_dv, t_hs, t_vs;

  assign run = (state_q == ST_RUN);

  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .run_i        (run),
    .h_cnt_o      (h_cnt),
    .v_cnt_o      (v_cnt),
    .frame_start_o(frame_start),
    .frame_end_o  (frame_end),
    .dv_o         (t_dv),
    .hs_o         (t_hs),
    .vs_o         (t_vs)
  );

  // en_i only matters in IDLE and at the last clock of a frame, so frames are never cut short
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_i) state_d = ST_RUN;
      default: if (frame_end && !en_i) state_d = ST_IDLE;
    endcase
  end

  // the first pixel of a frame already uses the newly latched pattern
  assign pat_d = frame_start ? pattern_i : pat_q;
  assign y_d   = (run && t_dv) ? pattern_pixel(pat_d, h_cnt, v_cnt) : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= PAT_HRAMP;
      y_q     <= 8'h00;
      dv_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      y_q     <= y_d;
      dv_q    <= run && t_dv;
      hs_q    <= (run && t_hs) ? HS_POL : ~HS_POL;
      vs_q    <= (run && t_vs) ? VS_POL : ~VS_POL;
      sof_q   <= frame_start && t_dv;
    end
  end

  assign vid.y_o    = y_q;
  assign vid.dv_o   = dv_q;
  assign vid.hs_o   = hs_q;
  assign vid.vs_o   = vs_q;
  assign vid.sof_o  = sof_q;
  assign vid.busy_o = run;

endmodule

// File: tb/tb_video_test_source.sv
// tb/tb_video_test_source.sv - scoreboard bench for video_test_source on a 14x7 raster
module tb_video_test_source;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_i = 1'b0;
  logic [1:0] pattern_i = 2'd0;

  video_test_source_if vif();

  video_test_source #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en_i),
    .pattern_i(pattern_i),
    .vid      (vif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic       sof;
  } pix_t;

  pix_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pixels of one 8x4 active area, optionally only the first n
  task automatic push_frame(input logic [1:0] pat, input int n);
    pix_t p;
    int   k;
    k = 0;
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 8; h++) begin
        if (k < n) begin
          case (pat)
            2'd0:    p.y = 8'(h);
            2'd1:    p.y = 8'(v);
            2'd2:    p.y = (((h >> 5) ^ (v >> 5)) & 1) != 0 ? 8'hFF : 8'h00;
            default: p.y = 8'h80;
          endcase
          p.sof = (h == 0) && (v == 0);
          exp_q.push_back(p);
        end
        k++;
      end
    end
  endtask

  always @(negedge clk) begin
    pix_t e;
    if (vif.dv_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dv", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pix_y", 32'(vif.y_o), 32'(e.y));
        chk("pix_sof", 32'(vif.sof_o), 32'(e.sof));
      end
    end else if (vif.sof_o) begin
      chk("sof_without_dv", 1, 0);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_y"},    32'(vif.y_o),    0);
    chk({tag, "_dv"},   32'(vif.dv_o),   0);
    chk({tag, "_hs"},   32'(vif.hs_o),   0);
    chk({tag, "_vs"},   32'(vif.vs_o),   0);
    chk({tag, "_sof"},  32'(vif.sof_o),  0);
    chk({tag, "_busy"}, 32'(vif.busy_o), 0);
  endtask

  // Count edges until the first dv_o; expects it on the 2nd edge
  task automatic wait_first_dv();
    int k;
    k = 9;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (vif.dv_o) begin
        k = i;
        break;
      end
    end
    chk("start_latency", k, 2);
    chk("start_sof", 32'(vif.sof_o), 1);
    chk("start_busy", 32'(vif.busy_o), 1);
  endtask

  // Called just after the negedge showing output index 0 of a frame
  task automatic run_frame(input int chg_t, input logic [1:0] chg_pat, input int push_pat,
                           input int drop_t, input int rst_t);
    int ln, lc;
    for (int t = 0; t < 98; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
        if (t == chg_t) begin
          pattern_i = chg_pat;
          if (push_pat >= 0) push_frame(push_pat[1:0], 32);
        end
        if (t == drop_t) en_i = 1'b0;
        if (t == rst_t) begin
          rst = 1'b1;
          @(negedge clk);
          chk_reset_vals("async_rst");
          return;
        end
        @(negedge clk);
      end
      ln = t / 14;
      lc = t % 14;
      chk("dv_timing", 32'(vif.dv_o), 32'((ln < 4) && (lc < 8)));
      chk("hs_timing", 32'(vif.hs_o), 32'((lc == 10) || (lc == 11)));
      chk("vs_timing", 32'(vif.vs_o), 32'(ln == 5));
      chk("busy", 32'(vif.busy_o), 32'((t < 97) || (drop_t < 0)));
    end
  endtask

  task automatic next_frame();
    @(posedge clk);
    @(negedge clk);
    chk("frame_period_sof", 32'(vif.sof_o), 1);
    chk("frame_period_dv", 32'(vif.dv_o), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("in_reset");
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_quiet", 32'({vif.y_o, vif.dv_o, vif.hs_o, vif.vs_o, vif.sof_o, vif.busy_o}), 0);
    end

    push_frame(2'd0, 32);
    @(posedge clk);
    #1 en_i = 1'b1;
    wait_first_dv();

    run_frame(50, 2'd1, 1, -1, -1);
    next_frame();
    run_frame(50, 2'd3, 3, -1, -1);
    next_frame();
    run_frame(50, 2'd0, 0, -1, -1);
    next_frame();
    run_frame(27, 2'd3, 3, -1, -1);
    next_frame();
    run_frame(-1, 2'd0, -1, 13, -1);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("after_stop", 32'({vif.dv_o, vif.busy_o, vif.sof_o}), 0);
    end

    pattern_i = 2'd0;
    push_frame(2'd0, 18);
    @(posedge clk);
    #1 en_i = 1'b1;
    wait_first_dv();
    run_frame(-1, 2'd0, -1, -1, 30);

    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_vals("held_rst");
    rst = 1'b0;
    push_frame(2'd0, 32);
    wait_first_dv();
    run_frame(-1, 2'd0, -1, 13, -1);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("final_idle", 32'({vif.dv_o, vif.busy_o}), 0);
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
